// File: rtl/axi4_sram_if.sv
// AXI4 bus bundle shared by the SRAM target and its initiators; all five channels, full-width beats.
interface axi4_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 128,
    parameter int AXI4_ID_WIDTH      = 4
);
    logic [AXI4_ID_WIDTH-1:0]        awid;
    logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
    logic [7:0]                      awlen;
    logic [2:0]                      awsize;
    logic [1:0]                      awburst;
    logic                            awvalid;
    logic                            awready;

    logic [AXI4_DATA_WIDTH-1:0]      wdata;
    logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [AXI4_ID_WIDTH-1:0]        bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    logic [AXI4_ID_WIDTH-1:0]        arid;
    logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
    logic [7:0]                      arlen;
    logic [2:0]                      arsize;
    logic [1:0]                      arburst;
    logic                            arvalid;
    logic                            arready;

    logic [AXI4_ID_WIDTH-1:0]        rid;
    logic [AXI4_DATA_WIDTH-1:0]      rdata;
    logic [1:0]                      rresp;
    logic                            rlast;
    logic                            rvalid;
    logic                            rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_sram.sv
// AXI4 SRAM target, one transaction at a time; define AXI4_SRAM_ERR_RESP_EN for SLVERR on out-of-range bursts.
// Latency: RVALID one cycle after AR, then one beat per cycle; BVALID the cycle after the final W beat.
// Backpressure: B and R outputs hold while the initiator stalls; AR is refused whenever AW is offered.
module axi4_sram #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 128,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int MEM_ADDR_BITS      = 10
) (
    input logic   clk,
    input logic   rst,
    axi4_if.slave s
);
    localparam int NBYTES = AXI4_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int TOP    = MEM_ADDR_BITS + OFF;
    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [7:0]               CNT_ONE  = 8'd1;
    localparam logic [1:0]               OKAY     = 2'b00;
    localparam logic [1:0]               SLVERR   = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                      state;
    logic [AXI4_DATA_WIDTH-1:0]  mem [0:(2**MEM_ADDR_BITS)-1];
    logic [MEM_ADDR_BITS-1:0]    addr;
    logic [MEM_ADDR_BITS-1:0]    addr_nxt;
    logic [AXI4_ID_WIDTH-1:0]    id;
    logic [7:0]                  len;
    logic [7:0]                  cnt;
    logic                        fixed;
    logic                        err;

    logic                        wready_q;
    logic                        bvalid_q;
    logic [AXI4_ID_WIDTH-1:0]    bid_q;
    logic [1:0]                  bresp_q;
    logic                        rvalid_q;
    logic [AXI4_ID_WIDTH-1:0]    rid_q;
    logic [1:0]                  rresp_q;
    logic                        rlast_q;
    logic [AXI4_DATA_WIDTH-1:0]  rdata_q;

    logic [MEM_ADDR_BITS-1:0]    aw_word;
    logic [MEM_ADDR_BITS-1:0]    ar_word;
    logic                        aw_err;
    logic                        ar_err;

    assign aw_word = s.awaddr[TOP-1:OFF];
    assign ar_word = s.araddr[TOP-1:OFF];

`ifdef AXI4_SRAM_ERR_RESP_EN
    assign aw_err = |s.awaddr[AXI4_ADDRESS_WIDTH-1:TOP];
    assign ar_err = |s.araddr[AXI4_ADDRESS_WIDTH-1:TOP];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // WRAP bursts deliberately advance like INCR; the counter wraps modulo the memory depth.
    assign addr_nxt = fixed ? addr : addr + ADDR_ONE;

    assign s.awready = (state == IDLE);
    assign s.arready = (state == IDLE) && !s.awvalid;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;
    assign s.rvalid  = rvalid_q;
    assign s.rid     = rid_q;
    assign s.rresp   = rresp_q;
    assign s.rlast   = rlast_q;
    assign s.rdata   = rdata_q;

    // Byte-lane writes; reset only gates new writes and never clears contents.
    always_ff @(posedge clk) begin
        if (!rst && state == WDATA && s.wvalid && !err) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (s.wstrb[i]) mem[addr][i*8 +: 8] <= s.wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rresp_q  <= OKAY;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s.awvalid) begin
                        id       <= s.awid;
                        addr     <= aw_word;
                        len      <= s.awlen;
                        fixed    <= (s.awburst == 2'b00);
                        err      <= aw_err;
                        cnt      <= 8'd0;
                        wready_q <= 1'b1;
                        state    <= WDATA;
                    end else if (s.arvalid) begin
                        id       <= s.arid;
                        addr     <= ar_word;
                        len      <= s.arlen;
                        fixed    <= (s.arburst == 2'b00);
                        err      <= ar_err;
                        cnt      <= 8'd0;
                        rvalid_q <= 1'b1;
                        rid_q    <= s.arid;
                        rresp_q  <= ar_err ? SLVERR : OKAY;
                        rlast_q  <= (s.arlen == 8'd0);
                        rdata_q  <= ar_err ? '0 : mem[ar_word];
                        state    <= RDATA;
                    end
                end
                WDATA: begin
                    if (s.wvalid) begin
                        addr <= addr_nxt;
                        cnt  <= cnt + CNT_ONE;
                        if (cnt == len) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id;
                            bresp_q  <= err ? SLVERR : OKAY;
                            state    <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (s.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RDATA: begin
                    if (s.rready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            addr    <= addr_nxt;
                            cnt     <= cnt + CNT_ONE;
                            rlast_q <= (cnt + CNT_ONE == len);
                            rdata_q <= err ? '0 : mem[addr_nxt];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, s.awaddr[OFF-1:0], s.araddr[OFF-1:0],
                         s.awaddr[AXI4_ADDRESS_WIDTH-1:TOP], s.araddr[AXI4_ADDRESS_WIDTH-1:TOP],
                         s.awsize, s.arsize, s.wlast};
endmodule

// File: tb/tb_axi4_sram.sv
// Randomised directed bench for axi4_sram against a byte-addressed memory model.
module tb_axi4_sram;
    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int IW    = 4;
    localparam int MAB   = 10;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** MAB;
    localparam int LIMIT = 200;

`ifdef AXI4_SRAM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_if #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) bus ();

    axi4_sram #(
        .AXI4_ADDRESS_WIDTH(AW),
        .AXI4_DATA_WIDTH(DW),
        .AXI4_ID_WIDTH(IW),
        .MEM_ADDR_BITS(MAB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]    ref_mem [DEPTH*NB];
    logic [DW-1:0] wdat [256];
    logic [NB-1:0] wstb [256];
    int            cur_w;
    bit            cur_err;
    bit            cur_fixed;
    logic [DW-1:0] last_rdata [256];

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a / NB) % DEPTH);
    endfunction

    function automatic bit oor(input logic [AW-1:0] a);
        return ERR_EN && ((a / (NB * DEPTH)) != 0);
    endfunction

    function automatic logic [DW-1:0] ref_word(input int w);
        logic [DW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = ref_mem[w*NB + b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [AW-1:0] addr, input int len, input int id, input int burst);
        int t;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awid    = IW'(id);
        bus.awburst = 2'(burst);
        bus.awsize  = 3'd4;
        bus.awvalid = 1'b1;
        t = 0;
        #1;
        while (!bus.awready && t < LIMIT) begin
            @(negedge clk); #1; t++;
        end
        chk("aw_wait", (t < LIMIT), 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        cur_w     = word_of(addr);
        cur_err   = oor(addr);
        cur_fixed = (burst == 0);
        #1;
        chk("busy_awready", bus.awready, 1'b0);
        chk("busy_arready", bus.arready, 1'b0);
        chk("wready_on", bus.wready, 1'b1);
    endtask

    task automatic w_beat(input logic [DW-1:0] data, input logic [NB-1:0] strb, input int gap, input bit last);
        int t;
        bus.wvalid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wlast  = last;
        bus.wvalid = 1'b1;
        t = 0;
        #1;
        while (!bus.wready && t < LIMIT) begin
            @(negedge clk); #1; t++;
        end
        chk("w_wait", (t < LIMIT), 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        if (!cur_err)
            for (int b = 0; b < NB; b++)
                if (strb[b]) ref_mem[cur_w*NB + b] = data[b*8 +: 8];
        if (!cur_fixed) cur_w = (cur_w + 1) % DEPTH;
    endtask

    task automatic b_recv(input int id, input int stall);
        int t;
        bus.bready = 1'b0;
        #1;
        chk("wready_off", bus.wready, 1'b0);
        for (int i = 0; i < stall; i++) begin
            chk("b_hold_vld", bus.bvalid, 1'b1);
            chk("b_hold_id", bus.bid, id);
            @(negedge clk); #1;
        end
        bus.bready = 1'b1;
        t = 0;
        #1;
        while (!bus.bvalid && t < LIMIT) begin
            @(negedge clk); #1; t++;
        end
        chk("b_wait", (t < LIMIT), 1'b1);
        chk("bid", bus.bid, id);
        chk("bresp", bus.bresp, cur_err ? 2'b10 : 2'b00);
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        #1;
        chk("b_done", bus.bvalid, 1'b0);
        chk("idle_awready", bus.awready, 1'b1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int len, input int id, input int burst,
                            input int bstall, input bit gaps);
        aw_send(addr, len, id, burst);
        for (int i = 0; i <= len; i++)
            w_beat(wdat[i], wstb[i], gaps ? int'($urandom_range(0, 1)) : 0, (i == len));
        b_recv(id, bstall);
    endtask

    // mode 0: RREADY always high, 1: random stalls, 2: toggle 1/0.
    task automatic do_read(input logic [AW-1:0] addr, input int len, input int id, input int burst, input int mode);
        int t, i, w;
        bit e, fx;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arid    = IW'(id);
        bus.arburst = 2'(burst);
        bus.arsize  = 3'd4;
        bus.arvalid = 1'b1;
        t = 0;
        #1;
        while (!bus.arready && t < LIMIT) begin
            @(negedge clk); #1; t++;
        end
        chk("ar_wait", (t < LIMIT), 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        w  = word_of(addr);
        e  = oor(addr);
        fx = (burst == 0);
        i  = 0;
        t  = 0;
        while (i <= len && t < 2000) begin
            bus.rready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : ((t % 2) == 0);
            #1;
            chk("rvalid", bus.rvalid, 1'b1);
            chk("rdata", bus.rdata, e ? {DW{1'b0}} : ref_word(w));
            chk("rlast", bus.rlast, (i == len));
            chk("rid", bus.rid, id);
            chk("rresp", bus.rresp, e ? 2'b10 : 2'b00);
            last_rdata[i % 256] = bus.rdata;
            if (bus.rready) begin
                i++;
                if (!fx) w = (w + 1) % DEPTH;
            end
            @(negedge clk);
            t++;
        end
        bus.rready = 1'b0;
        chk("r_bound", (t < 2000), 1'b1);
        #1;
        chk("r_done", bus.rvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        int len, burst;

        rst = 1'b1;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;
        repeat (3) @(negedge clk);
        chk("rst_awready", bus.awready, 1'b1);
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_bresp", bus.bresp, 2'b00);
        chk("rst_rresp", bus.rresp, 2'b00);
        chk("rst_bid", bus.bid, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill the whole memory with random words so every later read has a defined model value.
        for (int k = 0; k < DEPTH / 256; k++) begin
            for (int i = 0; i < 256; i++) begin
                wdat[i] = {$urandom, $urandom, $urandom, $urandom};
                wstb[i] = '1;
            end
            do_write(AW'(k * 256 * NB), 255, k, 1, 0, 1'b0);
        end

        // Basic 4-beat write with B backpressure, then streaming read.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = DW'(8'hA0 + i);
            wstb[i] = '1;
        end
        do_write(32'h100, 3, 5, 1, 3, 1'b0);
        do_read(32'h100, 3, 5, 1, 0);
        for (int i = 0; i < 4; i++) chk("basic_beat", last_rdata[i], DW'(8'hA0 + i));

        // Partial strobe over an all-ones word.
        wdat[0] = '1; wstb[0] = '1;
        do_write(32'h2000, 0, 1, 1, 0, 1'b0);
        wdat[0] = '0; wstb[0] = 16'h0001;
        do_write(32'h2000, 0, 2, 1, 1, 1'b0);
        do_read(32'h2000, 0, 2, 1, 1);
        chk("partial_strobe", last_rdata[0], {{(NB-1){8'hFF}}, 8'h00});

        // Simultaneous AW/AR: write wins, AR only after B, then toggled RREADY.
        @(negedge clk);
        bus.araddr = 32'h3000; bus.arlen = 8'd2; bus.arid = 4'd9; bus.arburst = 2'd1; bus.arvalid = 1'b1;
        bus.awaddr = 32'h3000; bus.awvalid = 1'b1;
        #1;
        chk("both_awready", bus.awready, 1'b1);
        chk("both_arready", bus.arready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wdat[i] = {$urandom, $urandom, $urandom, $urandom};
            wstb[i] = '1;
        end
        do_write(32'h3000, 2, 8, 1, 2, 1'b1);
        chk("ar_after_b", bus.arready, 1'b1);
        do_read(32'h3000, 2, 9, 1, 2);

        // FIXED burst keeps hitting one word.
        for (int i = 0; i < 3; i++) begin
            wdat[i] = {$urandom, $urandom, $urandom, $urandom};
            wstb[i] = NB'($urandom);
        end
        do_write(32'h1230, 2, 3, 0, 0, 1'b1);
        do_read(32'h1230, 2, 3, 0, 1);

        // 256-beat burst from the last word wraps to word 0.
        for (int i = 0; i < 256; i++) begin
            wdat[i] = {$urandom, $urandom, $urandom, $urandom};
            wstb[i] = '1;
        end
        do_write(AW'((DEPTH - 1) * NB), 255, 7, 1, 1, 1'b0);
        do_read(AW'((DEPTH - 1) * NB), 255, 7, 1, 1);

        // Out-of-range start: SLVERR and suppressed write, or aliasing when the check is compiled out.
        for (int i = 0; i < 2; i++) begin
            wdat[i] = {$urandom, $urandom, $urandom, $urandom};
            wstb[i] = '1;
        end
        do_write(32'h0001_0400, 1, 3, 1, 1, 1'b0);
        do_read(32'h0001_0400, 1, 4, 1, 0);
        do_read(32'h0000_0400, 1, 4, 1, 0);

        // Reset during beat 2 of a 4-beat write.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = {$urandom, $urandom, $urandom, $urandom};
            wstb[i] = '1;
        end
        aw_send(32'h5000, 3, 6, 1);
        w_beat(wdat[0], wstb[0], 0, 1'b0);
        w_beat(wdat[1], wstb[1], 0, 1'b0);
        bus.wdata = wdat[2]; bus.wstrb = '1; bus.wvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.wvalid = 1'b0;
        #1;
        chk("abort_wready", bus.wready, 1'b0);
        chk("abort_bvalid", bus.bvalid, 1'b0);
        chk("abort_rvalid", bus.rvalid, 1'b0);
        chk("abort_awready", bus.awready, 1'b1);
        do_read(32'h5000, 3, 6, 1, 0);

        // Random mixed traffic.
        for (int n = 0; n < 15; n++) begin
            a = AW'($urandom_range(0, NB * DEPTH - 1));
            if ($urandom_range(0, 4) == 0) a = a | (32'h1 << $urandom_range(14, 31));
            len   = $urandom_range(0, 7);
            burst = $urandom_range(0, 2);
            for (int i = 0; i <= len; i++) begin
                wdat[i] = {$urandom, $urandom, $urandom, $urandom};
                wstb[i] = NB'($urandom);
            end
            do_write(a, len, $urandom_range(0, 15), burst, $urandom_range(0, 2), 1'b1);
            do_read(a, len, $urandom_range(0, 15), burst, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
